// File: rtl/plic_claim_pkg.sv
// Shared types and constants for the PLIC claim/complete requester.
// Covers the top-level sequencing states, the APB phase states and the spurious claim ID.
package plic_claim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SETUP,
      ST_RD_ACCESS,
      ST_DELIVER,
      ST_SERVICE,
      ST_WR_SETUP,
      ST_WR_ACCESS,
      ST_HOLD
   } claim_state_e;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_phase_e;

   localparam int SPURIOUS_ID = 0;
   localparam int MAX_STRB_W  = 64;

   function automatic logic [MAX_STRB_W-1:0] strb_all_ones(input int n);
      strb_all_ones = '0;
      for (int i = 0; i < MAX_STRB_W; i++) begin
         if (i < n) strb_all_ones[i] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/plic_apb_req_fsm.sv
// Generic single-transfer APB4 requester with registered bus outputs and a saturating
// pready wait counter. done/rdata/slv_err/timeout are qualifiers for the caller's next-state logic.
module plic_apb_req_fsm #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_write,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic                    o_psel,
   output logic                    o_penable,
   output logic                    o_pwrite,
   output logic [ADDR_WIDTH-1:0]   o_paddr,
   output logic [DATA_WIDTH-1:0]   o_pwdata,
   output logic [DATA_WIDTH/8-1:0] o_pstrb,
   input  logic                    i_pready,
   input  logic                    i_pslv_err,
   input  logic [DATA_WIDTH-1:0]   i_prdata,
   output logic                    o_done,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic                    o_slv_err,
   output logic                    o_timeout
);
   import plic_claim_pkg::*;

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   apb_phase_e               r_state, w_state_next;
   logic                     r_psel, w_psel_next;
   logic                     r_penable, w_penable_next;
   logic                     r_pwrite, w_pwrite_next;
   logic [ADDR_WIDTH-1:0]    r_paddr, w_paddr_next;
   logic [DATA_WIDTH-1:0]    r_pwdata, w_pwdata_next;
   logic [STRB_W-1:0]        r_pstrb, w_pstrb_next;
   logic [CNT_W-1:0]         r_cnt, w_cnt_next;
   logic                     w_in_access;

   assign w_in_access = (r_state == APB_ACCESS);

   always_comb begin
      w_state_next   = r_state;
      w_psel_next    = r_psel;
      w_penable_next = r_penable;
      w_pwrite_next  = r_pwrite;
      w_paddr_next   = r_paddr;
      w_pwdata_next  = r_pwdata;
      w_pstrb_next   = r_pstrb;
      case (r_state)
         APB_IDLE: begin
            if (i_start) begin
               w_state_next  = APB_SETUP;
               w_psel_next   = 1'b1;
               w_pwrite_next = i_write;
               w_paddr_next  = i_addr;
               w_pwdata_next = i_write ? i_wdata : '0;
               w_pstrb_next  = i_write ? STRB_W'(strb_all_ones(STRB_W)) : '0;
            end
         end
         APB_SETUP: begin
            w_state_next   = APB_ACCESS;
            w_penable_next = 1'b1;
         end
         APB_ACCESS: begin
            if (i_pready) begin
               w_state_next   = APB_IDLE;
               w_psel_next    = 1'b0;
               w_penable_next = 1'b0;
               w_pwrite_next  = 1'b0;
               w_paddr_next   = '0;
               w_pwdata_next  = '0;
               w_pstrb_next   = '0;
            end
         end
         default: w_state_next = APB_IDLE;
      endcase
   end

   // Wait counter only advances across consecutive ACCESS cycles; it saturates so the pulse fires once.
   always_comb begin
      w_cnt_next = '0;
      if (w_in_access && (w_state_next == APB_ACCESS)) begin
         w_cnt_next = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= APB_IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_next;
         r_psel    <= w_psel_next;
         r_penable <= w_penable_next;
         r_pwrite  <= w_pwrite_next;
         r_paddr   <= w_paddr_next;
         r_pwdata  <= w_pwdata_next;
         r_pstrb   <= w_pstrb_next;
         r_cnt     <= w_cnt_next;
      end
   end

   assign o_psel    = r_psel;
   assign o_penable = r_penable;
   assign o_pwrite  = r_pwrite;
   assign o_paddr   = r_paddr;
   assign o_pwdata  = r_pwdata;
   assign o_pstrb   = r_pstrb;
   assign o_done    = w_in_access & i_pready;
   assign o_rdata   = i_prdata;
   assign o_slv_err = w_in_access & i_pready & i_pslv_err;
   assign o_timeout = w_in_access & ~i_pready & (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/plic_claim_master.sv
// Hart-side PLIC claim/complete sequencer: claims on irq, hands the ID to the core,
// waits for completion, writes the ID back, and backs off after spurious or failed claims.
module plic_claim_master #(
   parameter int                ADDR_WIDTH = 32,
   parameter int                DATA_WIDTH = 32,
   parameter int                IRQ_ID_W   = 6,
   parameter int                DOMAIN_W   = 2,
   parameter logic [ADDR_WIDTH-1:0] CLAIM_ADDR = 32'h0020_0004,
   parameter logic [2:0]        ACC_PPROT  = 3'b011,
   parameter int                ACC_DID    = 0,
   parameter int                HOLDOFF    = 4,
   parameter int                TIMEOUT    = 255
) (
   input  logic                    pclk_i,
   input  logic                    prst_i,
   input  logic                    irq_i,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   output logic [2:0]              pprot_o,
   output logic [DOMAIN_W-1:0]     acc_did_o,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pready_i,
   input  logic                    pslv_err_i,
   output logic                    id_vld_o,
   output logic [IRQ_ID_W-1:0]     id_o,
   input  logic                    id_ack_i,
   input  logic                    cpl_i,
   output logic                    busy_o,
   output logic                    err_o
);
   import plic_claim_pkg::*;

   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   claim_state_e          r_state, w_state_next;
   logic [IRQ_ID_W-1:0]   r_id, w_id_next;
   logic                  r_id_vld, w_id_vld_next;
   logic [HOLD_W-1:0]     r_hold_cnt, w_hold_next;
   logic                  r_busy, r_err;
   logic                  w_start, w_write;
   logic                  w_done, w_slv_err, w_timeout;
   logic [DATA_WIDTH-1:0] w_rdata, w_wdata;

   assign w_wdata = {{(DATA_WIDTH-IRQ_ID_W){1'b0}}, r_id};

   plic_apb_req_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .TIMEOUT    (TIMEOUT)
   ) u_apb (
      .i_clk      (pclk_i),
      .i_rst      (prst_i),
      .i_start    (w_start),
      .i_write    (w_write),
      .i_addr     (CLAIM_ADDR),
      .i_wdata    (w_wdata),
      .o_psel     (psel_o),
      .o_penable  (penable_o),
      .o_pwrite   (pwrite_o),
      .o_paddr    (paddr_o),
      .o_pwdata   (pwdata_o),
      .o_pstrb    (pstrb_o),
      .i_pready   (pready_i),
      .i_pslv_err (pslv_err_i),
      .i_prdata   (prdata_i),
      .o_done     (w_done),
      .o_rdata    (w_rdata),
      .o_slv_err  (w_slv_err),
      .o_timeout  (w_timeout)
   );

   always_comb begin
      w_state_next  = r_state;
      w_id_next     = r_id;
      w_id_vld_next = r_id_vld;
      w_hold_next   = r_hold_cnt;
      w_start       = 1'b0;
      w_write       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (irq_i) begin
               w_state_next = ST_RD_SETUP;
               w_start      = 1'b1;
            end
         end
         ST_RD_SETUP: w_state_next = ST_RD_ACCESS;
         ST_RD_ACCESS: begin
            if (w_done) begin
               if (w_slv_err || (w_rdata[IRQ_ID_W-1:0] == IRQ_ID_W'(SPURIOUS_ID))) begin
                  w_state_next = ST_HOLD;
                  w_hold_next  = HOLD_W'(HOLDOFF - 1);
               end else begin
                  w_state_next  = ST_DELIVER;
                  w_id_next     = w_rdata[IRQ_ID_W-1:0];
                  w_id_vld_next = 1'b1;
               end
            end
         end
         ST_DELIVER: begin
            if (r_id_vld && id_ack_i) begin
               w_state_next  = ST_SERVICE;
               w_id_vld_next = 1'b0;
            end
         end
         ST_SERVICE: begin
            if (cpl_i) begin
               w_state_next = ST_WR_SETUP;
               w_start      = 1'b1;
               w_write      = 1'b1;
            end
         end
         ST_WR_SETUP: w_state_next = ST_WR_ACCESS;
         ST_WR_ACCESS: begin
            // A failed complete is reported but never retried.
            if (w_done) w_state_next = ST_IDLE;
         end
         ST_HOLD: begin
            if (r_hold_cnt == '0) w_state_next = ST_IDLE;
            else                  w_hold_next  = r_hold_cnt - 1'b1;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         r_state    <= ST_IDLE;
         r_id       <= '0;
         r_id_vld   <= 1'b0;
         r_hold_cnt <= '0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_id       <= w_id_next;
         r_id_vld   <= w_id_vld_next;
         r_hold_cnt <= w_hold_next;
         r_busy     <= (w_state_next != ST_IDLE) && (w_state_next != ST_HOLD);
         r_err      <= w_slv_err | w_timeout;
      end
   end

   assign id_vld_o  = r_id_vld;
   assign id_o      = r_id;
   assign busy_o    = r_busy;
   assign err_o     = r_err;
   assign pprot_o   = ACC_PPROT;
   assign acc_did_o = DOMAIN_W'(ACC_DID);

endmodule
